// File: rtl/card_pkg.sv
// Shared types and constants for the card RAM linked-list reader.
// Card records hold value in bits [3:0] and suit in bits [5:4].
package card_pkg;

    localparam int CARD_ADDR_W = 10;
    localparam logic [CARD_ADDR_W-1:0] NULL_ADDR = 10'h3FF;
    localparam int NEXT_OFFSET = 8;
    localparam int MAX_CARDS = 52;

    typedef enum logic [1:0] {
        HEARTS,
        DIAMONDS,
        CLUBS,
        SPADES
    } suit_e;

    typedef struct packed {
        logic [3:0] value;
        logic [1:0] suit;
    } card_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_CARD,
        WAIT_CARD,
        RD_NEXT,
        WAIT_NEXT,
        PRESENT,
        FINISH
    } rd_state_e;

    function automatic logic card_value_ok(input logic [3:0] v);
        return (v != 4'd0) && (v <= 4'd13);
    endfunction

endpackage

// File: rtl/card_rd_delay.sv
// Delays the card RAM read strobe by RD_LAT cycles so the reader
// knows exactly which cycle carries valid mem_q data.
module card_rd_delay #(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic rd,
    output logic rd_ok
);

    logic [RD_LAT-1:0] sr;

    generate
        if (RD_LAT == 1) begin : g_one
            always_ff @(posedge clock or posedge reset) begin
                if (reset) sr <= '0;
                else       sr <= rd;
            end
        end else begin : g_many
            always_ff @(posedge clock or posedge reset) begin
                if (reset) sr <= '0;
                else       sr <= {sr[RD_LAT-2:0], rd};
            end
        end
    endgenerate

    assign rd_ok = sr[RD_LAT-1];

endmodule

// File: rtl/card_list_reader.sv
// Walks the card linked list in card RAM and streams cards out.
// Define CARD_READER_VALIDATE_EN to reject card values 0 and >13.
module card_list_reader #(
    parameter int ADDR_W = card_pkg::CARD_ADDR_W,
    parameter int NEXT_OFFSET = card_pkg::NEXT_OFFSET,
    parameter logic [ADDR_W-1:0] NULL_ADDR = card_pkg::NULL_ADDR,
    parameter int MAX_CARDS = card_pkg::MAX_CARDS,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_q,
    output logic              card_valid,
    input  logic              card_ready,
    output logic [3:0]        card_value,
    output logic [1:0]        card_suit,
    output logic [ADDR_W-1:0] card_addr,
    output logic              busy,
    output logic              done,
    output logic [5:0]        card_count,
    output logic              error
);

    import card_pkg::*;

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] nxt_ptr;
    card_t             card_q;
    logic [ADDR_W-1:0] card_addr_q;
    logic [5:0]        count_q;
    logic              error_q;
    logic              rd_ok;
    logic              accept;
    logic              last_card;
    logic              bad_card;
    logic              unused_bits;

    card_rd_delay #(
        .RD_LAT(RD_LAT)
    ) u_rd_delay (
        .clock(clock),
        .reset(reset),
        .rd   (mem_rd),
        .rd_ok(rd_ok)
    );

    assign unused_bits = ^mem_q[31:ADDR_W];

`ifdef CARD_READER_VALIDATE_EN
    assign bad_card = !card_value_ok(mem_q[3:0]);
`else
    assign bad_card = 1'b0;
`endif

    assign card_valid = (state == PRESENT);
    assign accept     = card_valid && card_ready;
    assign last_card  = (count_q == 6'(MAX_CARDS - 1));
    assign mem_rd     = (state == RD_CARD) || (state == RD_NEXT);
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign card_value = card_q.value;
    assign card_suit  = card_q.suit;
    assign card_addr  = card_addr_q;
    assign card_count = count_q;
    assign error      = error_q;

    always_comb begin
        mem_addr = '0;
        unique case (1'b1)
            (state == RD_CARD): mem_addr = cur;
            (state == RD_NEXT): mem_addr = cur + ADDR_W'(NEXT_OFFSET);
            default:            mem_addr = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (head_addr == NULL_ADDR) ? FINISH : RD_CARD;
                end
            end
            RD_CARD:   state_nxt = WAIT_CARD;
            WAIT_CARD: begin
                if (rd_ok) state_nxt = bad_card ? FINISH : RD_NEXT;
            end
            RD_NEXT:   state_nxt = WAIT_NEXT;
            WAIT_NEXT: begin
                if (rd_ok) state_nxt = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    if (nxt_ptr == NULL_ADDR || last_card) state_nxt = FINISH;
                    else                                    state_nxt = RD_CARD;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= '0;
            nxt_ptr     <= '0;
            card_q      <= '0;
            card_addr_q <= '0;
            count_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cur     <= head_addr;
                        count_q <= '0;
                        error_q <= 1'b0;
                    end
                end
                WAIT_CARD: begin
                    if (rd_ok && bad_card) begin
                        error_q <= 1'b1;
                    end else if (rd_ok) begin
                        card_q.value <= mem_q[3:0];
                        card_q.suit  <= mem_q[5:4];
                        card_addr_q  <= cur;
                    end
                end
                WAIT_NEXT: begin
                    if (rd_ok) nxt_ptr <= mem_q[ADDR_W-1:0];
                end
                PRESENT: begin
                    if (accept) begin
                        count_q <= count_q + 6'd1;
                        cur     <= nxt_ptr;
                        // running out of budget on a non-null pointer means a cycle
                        if (nxt_ptr != NULL_ADDR && last_card) error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_list_reader.sv
// Scoreboard bench for card_list_reader with a 1-cycle card RAM model.
// Stimulus pushes expected cards; a monitor pops them on each accept.
module tb_card_list_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  head_addr = '0;
    logic [9:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_q = '0;
    logic        card_valid;
    logic        card_ready = 1'b1;
    logic [3:0]  card_value;
    logic [1:0]  card_suit;
    logic [9:0]  card_addr;
    logic        busy;
    logic        done;
    logic [5:0]  card_count;
    logic        error;

    typedef struct {
        logic [3:0] v;
        logic [1:0] s;
        logic [9:0] a;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    int          valid_seen = 0;
    logic [31:0] mem [0:1023];
    logic        rd_pend = 1'b0;
    logic [9:0]  rd_pend_addr = '0;

    card_list_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .head_addr (head_addr),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_q     (mem_q),
        .card_valid(card_valid),
        .card_ready(card_ready),
        .card_value(card_value),
        .card_suit (card_suit),
        .card_addr (card_addr),
        .busy      (busy),
        .done      (done),
        .card_count(card_count),
        .error     (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        rd_pend      = mem_rd;
        rd_pend_addr = mem_addr;
        if (mem_rd) rd_count++;
    end

    always @(posedge clock) begin
        mem_q <= rd_pend ? mem[rd_pend_addr] : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && card_valid) begin
            valid_seen++;
            if (card_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL card_unexpected: got addr %0d expected none",
                             card_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("card_value", 32'(card_value), 32'(mon_e.v));
                    check("card_suit", 32'(card_suit), 32'(mon_e.s));
                    check("card_addr", 32'(card_addr), 32'(mon_e.a));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] v, input logic [1:0] s,
                        input logic [9:0] a);
        exp_q.push_back('{v, s, a});
    endtask

    task automatic do_start(input logic [9:0] a);
        tick();
        start     = 1'b1;
        head_addr = a;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!card_valid && n < 100) begin
            tick();
            n++;
        end
        if (!card_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_valid_timeout: got 0 expected 1", name);
        end
    endtask

    task automatic finish_check(input string name, input int cnt,
                                input int err);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 2000);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got 0 expected 1", name);
        end
        check({name, "_count"}, 32'(card_count), 32'(cnt));
        check({name, "_error"}, 32'(error), 32'(err));
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        @(negedge clock);
        check({name, "_busy_off"}, 32'(busy), 32'd0);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rc;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[100] = 32'h01;
        mem[108] = 32'd200;
        mem[200] = 32'h15;
        mem[208] = 32'd300;
        mem[300] = 32'h3D;
        mem[308] = 32'h3FF;
        mem[50]  = 32'h27;
        mem[58]  = 32'd50;
        mem[400] = 32'h12;
        mem[408] = 32'd500;
        mem[500] = 32'h0E;
        mem[508] = 32'h3FF;

        repeat (3) tick();
        check("rst_valid", 32'(card_valid), 32'd0);
        check("rst_ctrl", 32'({mem_rd, busy, done, error}), 32'd0);
        check("rst_addr", 32'({mem_addr, card_addr}), 32'd0);
        check("rst_card", 32'({card_value, card_suit, card_count}), 32'd0);
        reset = 1'b0;
        tick();

        // basic three-card walk
        rd_count = 0;
        push(4'd1, 2'd0, 10'd100);
        push(4'd5, 2'd1, 10'd200);
        push(4'd13, 2'd3, 10'd300);
        do_start(10'd100);
        check("basic_busy", 32'(busy), 32'd1);
        n = 0;
        while (!card_valid && n < 50) begin
            tick();
            n++;
        end
        check("first_latency", 32'(n + 1), 32'd5);
        finish_check("basic", 3, 0);
        check("basic_reads", 32'(rd_count), 32'd6);

        // backpressure on card 2
        rd_count   = 0;
        card_ready = 1'b0;
        push(4'd1, 2'd0, 10'd100);
        push(4'd5, 2'd1, 10'd200);
        push(4'd13, 2'd3, 10'd300);
        do_start(10'd100);
        wait_valid("bp1");
        card_ready = 1'b1;
        tick();
        card_ready = 1'b0;
        wait_valid("bp2");
        rc = rd_count;
        check("bp_reads_mid", 32'(rc), 32'd4);
        repeat (5) begin
            tick();
            check("stall_valid", 32'(card_valid), 32'd1);
            check("stall_fields", 32'({card_value, card_suit, card_addr}),
                  32'({4'd5, 2'd1, 10'd200}));
        end
        check("stall_reads", 32'(rd_count), 32'(rc));
        card_ready = 1'b1;
        finish_check("bp", 3, 0);
        check("bp_reads", 32'(rd_count), 32'd6);

        // self-loop overflows the card budget
        for (int i = 0; i < 52; i++) push(4'd7, 2'd2, 10'd50);
        do_start(10'd50);
        finish_check("loop", 52, 1);

        // null head: immediate done, no reads, error cleared
        rd_count   = 0;
        valid_seen = 0;
        do_start(10'h3FF);
        check("null_done", 32'(done), 32'd1);
        finish_check("null", 0, 0);
        check("null_reads", 32'(rd_count), 32'd0);
        check("null_valid", 32'(valid_seen), 32'd0);

`ifdef CARD_READER_VALIDATE_EN
        push(4'd2, 2'd1, 10'd400);
        do_start(10'd400);
        finish_check("validate", 1, 1);
`endif

        // async reset while waiting for the next pointer
        do_start(10'd100);
        repeat (3) tick();
        check("wn_busy", 32'(busy), 32'd1);
        check("wn_card_addr", 32'(card_addr), 32'd100);
        reset = 1'b1;
        #1;
        check("ar_ctrl", 32'({card_valid, mem_rd, busy, done, error}), 32'd0);
        check("ar_addr", 32'({mem_addr, card_addr}), 32'd0);
        check("ar_card", 32'({card_value, card_suit, card_count}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        push(4'd1, 2'd0, 10'd100);
        push(4'd5, 2'd1, 10'd200);
        push(4'd13, 2'd3, 10'd300);
        do_start(10'd100);
        finish_check("after_reset", 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/card_list_reader.md
Name: card_list_reader

Overview:
Reads back the linked list of cards that the card store writes into the 1024-entry card RAM. Given a head address, it fetches each card record and its next-card pointer. It presents cards one at a time on a valid/ready stream and ends the walk when it reaches the null pointer. It sits between the card RAM read port and the dealing and display logic.

Parameters:
ADDR_W, 10, card RAM address width
NEXT_OFFSET, 8, word offset from a card record to its next-card pointer (pointer at addr+NEXT_OFFSET)
NULL_ADDR, 10'h3FF, pointer value that terminates the list
MAX_CARDS, 52, maximum cards per walk before aborting as a loop
RD_LAT, 1, card RAM read latency in cycles (1 or 2)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a walk; ignored unless busy=0
head_addr  in  10  address of the first card record; sampled on start
mem_addr  out  10  card RAM read address
mem_rd  out  1  read strobe, high for exactly one cycle per read
mem_q  in  32  card RAM read data, valid RD_LAT cycles after mem_rd
card_valid  out  1  card output is valid
card_ready  in  1  consumer accepts the card when card_valid and card_ready are both high
card_value  out  4  card value (mem_q[3:0] of the card record)
card_suit  out  2  card suit (mem_q[5:4] of the card record)
card_addr  out  10  address of the presented card record
busy  out  1  high from the cycle after an accepted start until the cycle after done
done  out  1  one-cycle pulse when the walk ends
card_count  out  6  cards presented and accepted in the current or last walk
error  out  1  sticky; set on loop overflow; cleared by the next accepted start

Behaviour:
- Reset: state IDLE. card_valid, mem_rd, busy, done and error are 0. mem_addr, card_addr, card_value, card_suit and card_count are 0.
- States: IDLE, RD_CARD, WAIT_CARD, RD_NEXT, WAIT_NEXT, PRESENT, FINISH.
- IDLE, start=1:
  - if head_addr==NULL_ADDR, go to FINISH; done pulses and card_count=0.
  - otherwise latch cur=head_addr, clear card_count and error, go to RD_CARD.
- RD_CARD: mem_addr=cur, mem_rd=1. Wait RD_LAT cycles in WAIT_CARD, then latch value, suit and card_addr=cur.
- RD_NEXT: mem_addr=cur+NEXT_OFFSET, mod 2^10 (wraps; no error). Wait RD_LAT cycles in WAIT_NEXT, then latch nxt=mem_q[9:0].
- PRESENT: card_valid=1. Outputs stay stable until the handshake completes; card_valid never drops without an accept.
- On accept: card_count++.
  - if nxt==NULL_ADDR, go to FINISH.
  - else if card_count+1==MAX_CARDS, set error and go to FINISH.
  - else set cur=nxt and go to RD_CARD.
- Latency: first card_valid asserts exactly 2*(RD_LAT+1)+1 cycles after start. With card_ready held high, each further card follows at the same spacing.
- FINISH: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- start while busy=1 is ignored; it has no effect on the walk in progress.
- Asynchronous reset mid-walk abandons the walk immediately. No done pulse is issued.
- mem_rd is never asserted outside RD_CARD and RD_NEXT.

Optional Feature:
CARD_READER_VALIDATE_EN
- Defined: a card record whose value is 0 or greater than 13 sets error and goes straight to FINISH without presenting that card.
- Undefined: values are passed through unchecked.

Decomposition:
- Shared package card_pkg holds:
  - card_t struct (value[3:0], suit[1:0])
  - CARD_ADDR_W=10
  - NULL_ADDR and NEXT_OFFSET constants
  - suit enum (HEARTS, DIAMONDS, CLUBS, SPADES)
  - reader state enum
- One sub-module: card_rd_delay, an RD_LAT-deep shift register that turns mem_rd into a data-valid strobe. The FSM waits on that strobe.

Test Plan:
- Three-card list 100->200->300->NULL, values 1/5/13, suits 0/1/3, card_ready=1: three cards in order with correct card_addr, then card_count=3, one done pulse, error=0.
- head_addr=NULL_ADDR: done pulses 1 cycle after start, no mem_rd, card_valid stays 0, card_count=0.
- Backpressure: card_ready low for 5 cycles on card 2. card_valid and the card fields hold stable; no extra mem_rd is issued.
- Self-loop list (addr 50 with next=50): exactly 52 cards accepted, then error=1 and done pulses.
- Async reset asserted during WAIT_NEXT: all outputs are at reset values immediately. A new start then completes the walk normally.
- With CARD_READER_VALIDATE_EN defined, second card value 14: one card is presented, then error=1 and done pulses.
